// File: rtl/ofifo_pkg.sv
// ofifo_pkg: default geometry for the output FIFO. The SFP and PSUM SRAM
// stages import the same constants so all three agree on column count and
// psum width.
package ofifo_pkg;

  localparam int unsigned OFIFO_COL     = 8;   // independent psum columns
  localparam int unsigned OFIFO_PSUM_BW = 16;  // psum width per column
  localparam int unsigned OFIFO_DEPTH   = 16;  // entries per column (power of two)

endpackage : ofifo_pkg

// File: rtl/ofifo_col.sv
// ofifo_col: one column of the output FIFO. Holds storage, read/write
// pointers and the occupancy counter; head entry is shown combinationally.
//
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   wr_i          write request for this column (dropped when full, unless
//                 rd_i frees a slot in the same cycle)
//   din_i         psum to store
//   rd_i          read already qualified by the top (all columns non-empty)
//   head_c        entry at the read pointer
//   empty_c       column holds no entries
//   full_c        column holds depth entries
module ofifo_col
  import ofifo_pkg::*;
#(
  parameter int unsigned psum_bw = OFIFO_PSUM_BW,
  parameter int unsigned depth   = OFIFO_DEPTH
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               wr_i,
  input  logic [psum_bw-1:0] din_i,
  input  logic               rd_i,
  output logic [psum_bw-1:0] head_c,
  output logic               empty_c,
  output logic               full_c
);

  localparam int unsigned AW = $clog2(depth);
  localparam int unsigned PW = AW + 1;

  logic [psum_bw-1:0] mem_q [depth];
  logic [PW-1:0]      wptr_q, wptr_d;
  logic [PW-1:0]      rptr_q, rptr_d;
  logic [PW-1:0]      cnt_q,  cnt_d;
  logic               wr_acc_c;

  // Next-state for pointers and occupancy; a full column still accepts a
  // write when the same-cycle read vacates the slot being overwritten.
  always_comb begin
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    cnt_d    = cnt_q;
    full_c   = (cnt_q == PW'(depth));
    empty_c  = (cnt_q == '0);
    wr_acc_c = wr_i && (!full_c || rd_i);

    if (wr_acc_c) begin
      wptr_d = (wptr_q == PW'(depth - 1)) ? '0 : wptr_q + PW'(1);
    end
    if (rd_i) begin
      rptr_d = (rptr_q == PW'(depth - 1)) ? '0 : rptr_q + PW'(1);
    end

    case ({wr_acc_c, rd_i})
      2'b10:   cnt_d = cnt_q + PW'(1);
      2'b01:   cnt_d = cnt_q - PW'(1);
      default: cnt_d = cnt_q;
    endcase

    head_c = mem_q[rptr_q[AW-1:0]];
  end

  // Pointer and counter state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage is not reset; emptiness is tracked by the counter alone.
  always_ff @(posedge clk) begin
    if (wr_acc_c) begin
      mem_q[wptr_q[AW-1:0]] <= din_i;
    end
  end

endmodule : ofifo_col

// File: rtl/ofifo.sv
// ofifo: multi-column output FIFO behind the MAC array. Each column fills
// independently; a read pops one entry from every column at once and is
// only honoured when every column has data. Output is first-word-fall-
// through and forced to zero while not valid.
//
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   wr[col]       per-column write strobe
//   in            column psums, column k at [k*psum_bw +: psum_bw]
//   rd            pop one entry from all columns
//   out           head entries, same packing as in (zero when !o_valid)
//   o_valid       every column holds at least one entry
//   o_full        some column holds depth entries
//   o_ready       !o_full
//   err           (only with OFIFO_ERR_EN) sticky flag for a dropped write
//                 or an ignored read; cleared only by reset
module ofifo
  import ofifo_pkg::*;
#(
  parameter int unsigned col     = OFIFO_COL,
  parameter int unsigned psum_bw = OFIFO_PSUM_BW,
  parameter int unsigned depth   = OFIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [col-1:0]         wr,
  input  logic [col*psum_bw-1:0] in,
  input  logic                   rd,
  output logic [col*psum_bw-1:0] out,
  output logic                   o_valid,
  output logic                   o_full,
  output logic                   o_ready
`ifdef OFIFO_ERR_EN
  ,
  output logic                   err
`endif
);

  logic [col-1:0]         empty_c;
  logic [col-1:0]         full_c;
  logic [col*psum_bw-1:0] head_c;
  logic                   rd_acc_c;

  for (genvar k = 0; k < col; k++) begin : g_col
    ofifo_col #(
      .psum_bw (psum_bw),
      .depth   (depth)
    ) u_col (
      .clk     (clk),
      .reset_n (reset_n),
      .wr_i    (wr[k]),
      .din_i   (in[k*psum_bw +: psum_bw]),
      .rd_i    (rd_acc_c),
      .head_c  (head_c[k*psum_bw +: psum_bw]),
      .empty_c (empty_c[k]),
      .full_c  (full_c[k])
    );
  end

  // Status is a pure reduction of the column counters.
  assign o_valid  = ~|empty_c;
  assign o_full   = |full_c;
  assign o_ready  = ~o_full;
  assign rd_acc_c = rd & o_valid;
  assign out      = o_valid ? head_c : '0;

`ifdef OFIFO_ERR_EN
  logic err_q, err_d;

  // Dropped write: full column, no accepted read to make room.
  always_comb begin
    err_d = err_q
          | (|(wr & full_c & ~{col{rd_acc_c}}))
          | (rd & ~o_valid);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`endif

endmodule : ofifo
